// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types and constants for the MEM-stage data memory.
package data_memory_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
    localparam logic [1:0]  SIZE_BYTE     = 2'b00;
    localparam logic [1:0]  SIZE_HALF     = 2'b01;
    localparam logic [1:0]  SIZE_WORD     = 2'b10;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: pipeline-side request/response bundle of the MEM-stage data memory.
interface data_memory_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        stall;
    logic        ready;
    logic [31:0] read_data;
    logic        fault;
    modport master (
        output mem_read, mem_write, size, sign_ext, address, write_data,
        input  stall, ready, read_data, fault
    );
    modport slave (
        input  mem_read, mem_write, size, sign_ext, address, write_data,
        output stall, ready, read_data, fault
    );
endinterface

// File: rtl/data_memory_array.sv
// data_memory_array: DEPTH x 32 flop array, byte-enable write, combinational read, async clear.
module data_memory_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem_q [DEPTH];
    assign rdata = mem_q[idx];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule

// File: rtl/data_memory_stage.sv
// data_memory_stage: MEM-stage data memory with byte/half/word access, misalignment fault
// and a fixed wait-state latency reported through stall/ready.
module data_memory_stage
    import data_memory_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_STATES + 1);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   read_data_q, offset, rword, wlanes, shifted, ld;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [15:0]   ld_h;
    logic          fault_q, req, last, mis, we;
    assign req    = bus.mem_read | bus.mem_write;
    assign offset = bus.address - BASE_ADDR;
    assign idx    = AW'(offset >> 2);
    assign mis    = (bus.size == SIZE_HALF && bus.address[0]) || (bus.size[1] && bus.address[1:0] != 2'b00);
    // the edge ending the final stall cycle commits the store and captures the load
    assign last   = (state_q == S_IDLE && req && WAIT_STATES == 1) || (state_q == S_WAIT && cnt_q == CW'(1));
    assign we     = last & bus.mem_write & ~mis;
    assign be     = bus.size == SIZE_BYTE ? 4'b0001 << bus.address[1:0] :
                    bus.size == SIZE_HALF ? (bus.address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlanes = bus.size == SIZE_BYTE ? {4{bus.write_data[7:0]}} :
                    bus.size == SIZE_HALF ? {2{bus.write_data[15:0]}} : bus.write_data;
    assign shifted = rword >> {bus.address[1:0], 3'b000};
    assign ld_h    = bus.address[1] ? rword[31:16] : rword[15:0];
    assign ld      = bus.size == SIZE_BYTE ? {{24{bus.sign_ext & shifted[7]}}, shifted[7:0]} :
                     bus.size == SIZE_HALF ? {{16{bus.sign_ext & ld_h[15]}}, ld_h} : rword;
    data_memory_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .be    (be),
        .idx   (idx),
        .wdata (wlanes),
        .rdata (rword)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE && req) begin
            cnt_d   = CW'(WAIT_STATES - 1);
            state_d = WAIT_STATES > 1 ? S_WAIT : S_DONE;
        end else if (state_q == S_WAIT) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? S_DONE : S_WAIT;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (last) fault_q <= mis;
            if (last && !bus.mem_write) read_data_q <= mis ? '0 : ld;
        end
    end
    // gated by reset so a request held on the inputs cannot stall a pipeline under reset
    assign bus.stall     = rst & ((state_q == S_IDLE && req) || state_q == S_WAIT);
    assign bus.ready     = state_q == S_DONE;
    assign bus.read_data = read_data_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_data_memory_stage.sv
// tb_data_memory_stage: directed bench with a byte-array reference model checked every cycle,
// run against a WAIT_STATES=2 instance and a WAIT_STATES=1 instance.
module tb_data_memory_stage;
    logic clk = 1'b0, rst = 1'b0, sel = 1'b0, chk_en = 1'b0;
    logic mr = 1'b0, mw = 1'b0, sx = 1'b0;
    logic [1:0] sz = 2'b00;
    logic [31:0] ad = '0, wd = '0;
    logic exp_stall = 1'b0, exp_ready = 1'b0, exp_fault = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [7:0] mem_m [256];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    data_memory_if if0 ();
    data_memory_if if1 ();
    assign if0.mem_read = mr & ~sel;
    assign if0.mem_write = mw & ~sel;
    assign if1.mem_read = mr & sel;
    assign if1.mem_write = mw & sel;
    assign if0.size = sz;
    assign if1.size = sz;
    assign if0.sign_ext = sx;
    assign if1.sign_ext = sx;
    assign if0.address = ad;
    assign if1.address = ad;
    assign if0.write_data = wd;
    assign if1.write_data = wd;
    data_memory_stage #(.DEPTH(64), .WAIT_STATES(2), .BASE_ADDR(32'd1024)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    data_memory_stage #(.DEPTH(64), .WAIT_STATES(1), .BASE_ADDR(32'd1024)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    wire        d_stall = sel ? if1.stall : if0.stall;
    wire        d_ready = sel ? if1.ready : if0.ready;
    wire        d_fault = sel ? if1.fault : if0.fault;
    wire [31:0] d_rd    = sel ? if1.read_data : if0.read_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("stall", {31'd0, d_stall}, {31'd0, exp_stall});
        chk("ready", {31'd0, d_ready}, {31'd0, exp_ready});
        chk("fault", {31'd0, d_fault}, {31'd0, exp_fault});
        chk("read_data", d_rd, exp_rd);
    end

    logic        prev_stall = 1'b0;
    logic [69:0] held = '0;
    always @(negedge clk) begin
        if (rst && prev_stall) chk("inputs_stable", {31'd0, held == {mr, mw, sz, sx, ad, wd}}, 32'd1);
        prev_stall = rst & d_stall;
        held = {mr, mw, sz, sx, ad, wd};
    end

    // Reference: the array is a flat byte store; timing follows from the wait-state count alone.
    task automatic access(input logic r, input logic w, input logic [1:0] s, input logic x,
                          input logic [31:0] a, input logic [31:0] d);
        int ws = sel ? 1 : 2;
        int n, base;
        logic bad;
        logic [31:0] v;
        @(posedge clk); #1;
        mr = r; mw = w; sz = s; sx = x; ad = a; wd = d;
        exp_stall = 1'b1; exp_ready = 1'b0;
        repeat (ws - 1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        exp_stall = 1'b0; exp_ready = 1'b1;
        n = s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
        bad = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        base = int'(((a - 32'd1024) >> 2) % 64) * 4 + (n == 1 ? int'(a[1:0]) : n == 2 ? int'(a[1]) * 2 : 0);
        exp_fault = bad;
        if (w) begin
            if (!bad) for (int j = 0; j < n; j++) mem_m[base + j] = d[8*j +: 8];
        end else begin
            v = '0;
            for (int j = 0; j < n; j++) v[8*j +: 8] = mem_m[base + j];
            if (x && n < 4 && v[8*n-1]) for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
            exp_rd = bad ? '0 : v;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        mr = 1'b0; mw = 1'b0; exp_ready = 1'b0;
    endtask

    task automatic reset_all();
        chk_en = 1'b0;
        rst = 1'b0; mr = 1'b0; mw = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        exp_stall = 1'b0; exp_ready = 1'b0; exp_fault = 1'b0; exp_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", d_rd, 32'h0);
        chk("rst_flags", {29'd0, d_stall, d_ready, d_fault}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; chk_en = 1'b1;
    endtask

    initial begin
        reset_all();
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1028, 32'hDEADBEEF);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0);
        chk("ld_word", d_rd, 32'hDEADBEEF);
        chk("ld_word_ready", {31'd0, d_ready}, 32'd1);
        idle();
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'd1030, 32'h00000080);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'd1030, 32'h0);
        chk("ld_byte_sx", d_rd, 32'hFFFFFF80);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'd1030, 32'h0);
        chk("ld_byte_zx", d_rd, 32'h00000080);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0);
        chk("ld_word_merged", d_rd, 32'hDE80BEEF);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'd1029, 32'h0);
        chk("ld_half_misaligned", {d_rd[30:0], d_fault}, 32'h1);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1026, 32'hCAFEF00D);
        chk("st_word_misaligned", {31'd0, d_fault}, 32'd1);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0);
        chk("st_suppressed", d_rd, 32'h0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0);
        chk("word1_intact", d_rd, 32'hDE80BEEF);
        access(1'b1, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h12345678);
        chk("rw_keeps_rd", d_rd, 32'hDE80BEEF);
        idle();
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0);
        chk("rw_stored", d_rd, 32'h12345678);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'd1034, 32'h12348001);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1032, 32'h0);
        chk("half_lane_hi", d_rd, 32'h80010000);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'd1034, 32'h0);
        chk("ld_half_zx", d_rd, 32'h00008001);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1280, 32'hA5A55A5A);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0);
        chk("wrap_word0", d_rd, 32'hA5A55A5A);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'd1282, 32'h0);
        chk("wrap_half_sx", d_rd, 32'hFFFFA5A5);
        idle();
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1036, 32'h11112222);
        idle();
        @(posedge clk); #1;
        mr = 1'b0; mw = 1'b1; sz = 2'b10; sx = 1'b0; ad = 32'd1040; wd = 32'h33334444;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_wait_stall", {31'd0, d_stall}, 32'd1);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_stall", {30'd0, d_stall, d_ready}, 32'h0);
        chk("rst_mid_out", {d_rd[30:0], d_fault}, 32'h0);
        mw = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        exp_stall = 1'b0; exp_ready = 1'b0; exp_fault = 1'b0; exp_rd = '0;
        @(posedge clk); #1;
        rst = 1'b1; chk_en = 1'b1;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1036, 32'h0);
        chk("cleared_1036", d_rd, 32'h0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1040, 32'h0);
        chk("aborted_1040", d_rd, 32'h0);
        idle();
        sel = 1'b1;
        reset_all();
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1280, 32'h0BADF00D);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0);
        chk("ws1_wrap", d_rd, 32'h0BADF00D);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'd1027, 32'h0);
        chk("ws1_byte", d_rd, 32'h0000000B);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd1030, 32'h0);
        chk("ws1_fault", {d_rd[30:0], d_fault}, 32'h1);
        idle();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_stage.md
# data_memory_stage

Parametrised MEM-stage data memory unit: the successor to the single-cycle, word-only memory stage. It adds byte/halfword/word access with sign extension, misalignment detection, and a configurable wait-state latency. The latency is exposed to the pipeline through a `stall` output. It sits between the EXE/MEM and MEM/WB pipeline registers. The hazard/freeze logic ORs `stall` into the pipeline freeze.

## Interface
- `DEPTH`, 64: number of 32-bit words in the array; power of two, ≥ 4.
- `WAIT_STATES`, 2: cycles `stall` is high per access; ≥ 1.
- `BASE_ADDR`, 32'd1024: byte address mapped to word 0.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `size`  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `sign_ext`  in  1  sign-extend byte/halfword loads; 0 zero-extends.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Rm value); low bytes used for byte/halfword.
- `stall`  out  1  access in progress; pipeline must freeze and hold all inputs stable.
- `ready`  out  1  access complete this cycle; `read_data`/`fault` valid.
- `read_data`  out  32  load result, registered.
- `fault`  out  1  misaligned access, registered.

## Operation
- Request: `mem_read | mem_write` while in IDLE. If both are high, it is a store; `read_data` is unchanged.
- Word index: `(address - BASE_ADDR) >> 2`, truncated to `$clog2(DEPTH)` bits, so out-of-range addresses wrap silently.
- Lane mapping is little-endian. Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
- Misaligned access: halfword with `addr[0]=1`, or word/reserved with `addr[1:0]≠0`. It sets `fault=1`, suppresses the store, and forces `read_data=0`. Latency is unchanged.
- Stores write only the addressed byte lanes. Other lanes keep their contents.
- Loads: the selected lane(s) are right-justified, then sign- or zero-extended per `sign_ext`. Word loads ignore `sign_ext`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE + request: load the counter with `WAIT_STATES-1`. Go to WAIT if `WAIT_STATES>1`, else to DONE.
  - WAIT: decrement the counter. When the counter equals 1, go to DONE.
  - DONE → IDLE unconditionally. The request still on the inputs during DONE is the completed one and must not restart.
  - IDLE with no request stays in IDLE.
- `stall` is combinational: `(IDLE & request) | WAIT`. It is low in DONE.
- `ready` = (state == DONE).

## Timing
- The request cycle counts as stall cycle 1. `stall` is high for exactly `WAIT_STATES` consecutive cycles.
- The array write and the `read_data`/`fault` capture happen on the edge ending the last stall cycle, which is the edge entering DONE.
- `ready=1` for exactly one cycle (DONE). The pipeline advances at the end of DONE.
- Total occupancy per access is `WAIT_STATES+1` cycles. A back-to-back request is accepted in the cycle after DONE.
- `read_data` and `fault` hold their values until the next completed access. A store completion clears `fault` unless the store itself faulted.
- Reset (async, any state):
  - FSM goes to IDLE, counter to 0.
  - `stall`, `ready`, `fault` go to 0; `read_data` goes to 0.
  - All array words are cleared to 0.
  - A pending store is aborted with no partial write.
- Input changes during `stall` are a protocol violation and the result is undefined. The bench asserts inputs are stable.

## Structure
- Package `data_memory_pkg` holds:
  - the FSM state enum;
  - the `size` encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`);
  - the default `BASE_ADDR`.
- Sub-module `data_memory_array`: `DEPTH×32` flop array with a 4-bit byte-enable write, combinational read, and async active-low clear.
- FSM, counter, alignment check, lane steering and extension all live in the top module.

## Test plan
- Reset, then store word 0xDEADBEEF at 1028 and load word 1028, with WAIT_STATES=2 → `stall` high 2 cycles per access; `ready` pulses once; `read_data=0xDEADBEEF`; `fault=0`.
- Store byte 0x80 at 1030, then load byte 1030 with `sign_ext=1` → 0xFFFFFF80. With `sign_ext=0` → 0x00000080. A following word load at 1028 returns 0xDE80BEEF.
- Halfword load at 1029 → `fault=1`, `read_data=0`. A word store to 1026 → `fault=1` and array contents unchanged (verified by a following aligned load).
- `mem_read=mem_write=1`, address 1024, data 0x12345678 → store performed; `read_data` keeps its previous value; a later load returns 0x12345678.
- Address `1024+4*DEPTH` (DEPTH=64) → wraps to word 0; a load at 1024 returns the stored value. Repeat with WAIT_STATES=1: `stall` high 1 cycle, DONE follows immediately.
- Assert `rst` low in the middle of the WAIT state of a store → `stall` drops immediately; FSM is in IDLE; the target word reads 0 after reset.
